sample_loader: RTL and testbench
================================

Name: sample_loader

Overview:
Input sample buffer that sits directly upstream of the transform datapath and alongside the Controller FSM.
- Under Controller strobes (dt_load, dl_en, cnt_en), it captures one frame of N input samples through a valid/ready handshake.
- It holds the frame as a parallel bus for the HWT/DCT/DFT engines.
- It returns the shared 4-bit count that the Controller uses for its state transitions.

Parameters:
DATA_W, 8, width of one input sample (signed, two's complement, passed through unmodified)
N, 8, samples per frame; legal range 2..15 (count is fixed at 4 bits)

Ports:
clock  input  1  single system clock; all state updates on rising edge
rst  input  1  synchronous active-low reset; rst=0 at a rising edge resets the block
dt_load  input  1  Controller strobe: start a new frame (clear count, flags, buffer)
dl_en  input  1  Controller: load window open; samples may be accepted
cnt_en  input  1  Controller: advance count by one per cycle while dl_en=0 (transform step counting)
data_in  input  DATA_W  input sample
data_in_valid  input  1  source asserts when data_in is valid
data_ready  output  1  block can accept data_in this cycle (combinational)
count  output  4  shared sample/step counter to Controller
frame_full  output  1  N samples captured; buffer frozen
overrun  output  1  sticky: valid data offered while frame_full and dl_en=1
samples  output  N*DATA_W  frame buffer; sample k at bits [k*DATA_W +: DATA_W]

Behaviour:
- Reset (rst=0 at a clock edge): count=0, frame_full=0, overrun=0, all samples=0. Reset takes effect mid-frame as well, with no partial retention. While rst=0, data_ready=0.
- data_ready = rst & dl_en & ~frame_full & ~dt_load.
- Accept condition: accept = data_in_valid & data_ready.
- Priority at each edge (rst=1): dt_load > accept > cnt_en.
- dt_load=1:
  - count<=0, frame_full<=0, overrun<=0, all samples<=0.
  - Any concurrent data is not accepted (data_ready is low).
  - cnt_en is ignored that cycle.
- Accept:
  - samples[count]<=data_in; count<=count+1.
  - If count==N-1 at the accept edge, frame_full<=1 in the same edge, so count reads N the next cycle.
  - Accept latency: a sample presented at edge k is visible on samples from k+1.
- dl_en=1 with no accept: count and samples hold. cnt_en is ignored while dl_en=1.
- cnt_en=1, dl_en=0, dt_load=0: count<=count+1 every cycle.
  - Wraps 4'hF→4'h0 with no flag.
  - samples and frame_full are unchanged.
- frame_full=1: samples are frozen until dt_load or reset. data_ready is held 0.
- Overrun: if dl_en=1, data_in_valid=1 and frame_full=1 at an edge, overrun<=1. It stays set until dt_load or reset.
- data_in_valid with dl_en=0 is ignored: no accept and no overrun.
- Registered outputs: count, frame_full, overrun and samples. data_ready is the only combinational output.
- No arithmetic on sample data. Count addition is 4-bit modulo 16.

Test Plan:
- Reset: hold rst=0 for 2 cycles with data_in_valid=1, dl_en=1 → count=0, frame_full=0, overrun=0, samples=0, data_ready=0. Release rst=1 → data_ready=1.
- Full frame (N=8): pulse dt_load, then dl_en=1 with data_in 8'h01..8'h08 on 8 back-to-back valid cycles.
  - count steps 1..8; frame_full=1 after the 8th edge.
  - samples[0]=8'h01 ... samples[7]=8'h08; data_ready=0 afterwards.
- Backpressure gaps: valid toggled 1,0,1,0 with data 8'hA0, 8'hFF, 8'hA1, 8'hFF → only 8'hA0 and 8'hA1 stored at indices 0 and 1; count=2.
- Overrun: after a full frame, hold dl_en=1 and valid=1 for 1 cycle → overrun=1 and samples unchanged. A following dt_load pulse → overrun=0, count=0, samples=0.
- Step counting: after a full frame (count=8), set dl_en=0 and cnt_en=1 for 9 cycles → count 9..15, then 0, then 1. frame_full stays 1 and samples are unchanged.
- Collisions:
  - dt_load=1 with valid=1 and dl_en=1 at count=3 → count=0 and no sample stored.
  - rst=0 mid-frame at count=5 → all outputs return to reset values on that edge.

Source files
------------

// File: rtl/sample_loader.sv
// Input frame buffer: captures N samples through a valid/ready handshake under
// Controller strobes and exposes them as a parallel bus plus a shared 4-bit count.
module sample_loader #(
    parameter int DATA_W = 8,
    parameter int N      = 8
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  dt_load,
    input  logic                  dl_en,
    input  logic                  cnt_en,
    input  logic [DATA_W-1:0]     data_in,
    input  logic                  data_in_valid,
    output logic                  data_ready,
    output logic [3:0]            count,
    output logic                  frame_full,
    output logic                  overrun,
    output logic [N*DATA_W-1:0]   samples
);

    localparam logic [3:0] LAST_IDX = 4'(N - 1);

    logic [3:0]        count_reg, count_next;
    logic              frame_full_reg, frame_full_next;
    logic              overrun_reg, overrun_next;
    logic [DATA_W-1:0] sample_reg [N];
    logic              accept;

    assign data_ready = rst & dl_en & ~frame_full_reg & ~dt_load;
    assign accept     = data_in_valid & data_ready;

    // Priority: dt_load > accept > cnt_en. Step counting only runs outside the load window.
    always_comb begin
        count_next      = count_reg;
        frame_full_next = frame_full_reg;
        overrun_next    = overrun_reg;
        if (dt_load) begin
            count_next      = 4'd0;
            frame_full_next = 1'b0;
            overrun_next    = 1'b0;
        end else begin
            if (accept) begin
                count_next = count_reg + 4'd1;
                if (count_reg == LAST_IDX) begin
                    frame_full_next = 1'b1;
                end
            end else if (cnt_en && !dl_en) begin
                count_next = count_reg + 4'd1;
            end
            if (dl_en && data_in_valid && frame_full_reg) begin
                overrun_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!rst) begin
            count_reg      <= 4'd0;
            frame_full_reg <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            count_reg      <= count_next;
            frame_full_reg <= frame_full_next;
            overrun_reg    <= overrun_next;
        end
    end

    // One register per slot; a slot loads only when the running count points at it.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_slot
            always_ff @(posedge clock) begin
                if (!rst || dt_load) begin
                    sample_reg[gi] <= '0;
                end else if (accept && (count_reg == 4'(gi))) begin
                    sample_reg[gi] <= data_in;
                end
            end
            assign samples[gi*DATA_W +: DATA_W] = sample_reg[gi];
        end
    endgenerate

    assign count      = count_reg;
    assign frame_full = frame_full_reg;
    assign overrun    = overrun_reg;

endmodule

// File: tb/tb_sample_loader.sv
// Directed bench for sample_loader (N=8, DATA_W=8): one task per scenario,
// inputs driven 1ns after the rising edge and outputs sampled at the same point.
module tb_sample_loader;

    logic        clock = 1'b0;
    logic        rst;
    logic        dt_load;
    logic        dl_en;
    logic        cnt_en;
    logic [7:0]  data_in;
    logic        data_in_valid;
    logic        data_ready;
    logic [3:0]  count;
    logic        frame_full;
    logic        overrun;
    logic [63:0] samples;

    int checks = 0;
    int errors = 0;

    sample_loader #(.DATA_W(8), .N(8)) dut (
        .clock         (clock),
        .rst           (rst),
        .dt_load       (dt_load),
        .dl_en         (dl_en),
        .cnt_en        (cnt_en),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_ready    (data_ready),
        .count         (count),
        .frame_full    (frame_full),
        .overrun       (overrun),
        .samples       (samples)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [7:0] get_sample(input int k);
        return samples[k*8 +: 8];
    endfunction

    task automatic pulse_dt_load();
        dt_load = 1'b1;
        tick();
        dt_load = 1'b0;
    endtask

    task automatic load_samples(input int n, input logic [7:0] base);
        dl_en = 1'b1;
        data_in_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            data_in = base + 8'(i);
            tick();
        end
        data_in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        dl_en = 1'b1;
        data_in_valid = 1'b1;
        data_in = 8'h55;
        tick();
        tick();
        checks++;
        if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %h exp 0", count); end
        checks++;
        if (frame_full !== 1'b0) begin errors++; $display("FAIL reset_frame_full got %b exp 0", frame_full); end
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", overrun); end
        checks++;
        if (samples !== 64'h0) begin errors++; $display("FAIL reset_samples got %h exp 0", samples); end
        checks++;
        if (data_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low got %b exp 0", data_ready); end
        data_in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (data_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b exp 1", data_ready); end
        $display("test_reset done: count=%0d ready=%b", count, data_ready);
        dl_en = 1'b0;
    endtask

    task automatic test_full_frame();
        pulse_dt_load();
        checks++;
        if (count !== 4'd0) begin errors++; $display("FAIL frame_start_count got %h exp 0", count); end
        dl_en = 1'b1;
        data_in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            data_in = 8'(i + 1);
            tick();
            checks++;
            if (count !== 4'(i + 1)) begin errors++; $display("FAIL frame_count[%0d] got %h exp %h", i, count, 4'(i + 1)); end
            checks++;
            if (frame_full !== (i == 7)) begin errors++; $display("FAIL frame_full[%0d] got %b exp %b", i, frame_full, (i == 7)); end
            $display("accept %0d data=%h count=%0d full=%b", i, data_in, count, frame_full);
        end
        data_in_valid = 1'b0;
        #1;
        checks++;
        if (samples !== 64'h0807060504030201) begin errors++; $display("FAIL frame_samples got %h exp 0807060504030201", samples); end
        checks++;
        if (data_ready !== 1'b0) begin errors++; $display("FAIL frame_ready_after_full got %b exp 0", data_ready); end
    endtask

    task automatic test_overrun();
        data_in = 8'hEE;
        data_in_valid = 1'b1;
        tick();
        data_in_valid = 1'b0;
        checks++;
        if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set got %b exp 1", overrun); end
        checks++;
        if (samples !== 64'h0807060504030201) begin errors++; $display("FAIL overrun_samples_frozen got %h exp 0807060504030201", samples); end
        checks++;
        if (count !== 4'd8) begin errors++; $display("FAIL overrun_count got %h exp 8", count); end
        tick();
        checks++;
        if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky got %b exp 1", overrun); end
        pulse_dt_load();
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear got %b exp 0", overrun); end
        checks++;
        if (count !== 4'd0) begin errors++; $display("FAIL overrun_clear_count got %h exp 0", count); end
        checks++;
        if (samples !== 64'h0) begin errors++; $display("FAIL overrun_clear_samples got %h exp 0", samples); end
        checks++;
        if (frame_full !== 1'b0) begin errors++; $display("FAIL overrun_clear_full got %b exp 0", frame_full); end
        $display("test_overrun done: overrun=%b count=%0d", overrun, count);
    endtask

    task automatic test_step_count();
        logic [3:0] exp_count;
        pulse_dt_load();
        load_samples(8, 8'h10);
        checks++;
        if (frame_full !== 1'b1) begin errors++; $display("FAIL step_setup_full got %b exp 1", frame_full); end
        dl_en = 1'b0;
        cnt_en = 1'b1;
        exp_count = 4'd8;
        for (int i = 0; i < 9; i++) begin
            tick();
            exp_count = exp_count + 4'd1;
            checks++;
            if (count !== exp_count) begin errors++; $display("FAIL step_count[%0d] got %h exp %h", i, count, exp_count); end
            checks++;
            if (frame_full !== 1'b1) begin errors++; $display("FAIL step_full[%0d] got %b exp 1", i, frame_full); end
            $display("step %0d count=%0d", i, count);
        end
        cnt_en = 1'b0;
        checks++;
        if (exp_count !== 4'd1) begin errors++; $display("FAIL step_wrap_model got %h exp 1", exp_count); end
        checks++;
        if (samples !== 64'h1716151413121110) begin errors++; $display("FAIL step_samples got %h exp 1716151413121110", samples); end
    endtask

    task automatic test_backpressure();
        logic [7:0] dat [4];
        logic       vld [4];
        dat = '{8'hA0, 8'hFF, 8'hA1, 8'hFF};
        vld = '{1'b1, 1'b0, 1'b1, 1'b0};
        pulse_dt_load();
        dl_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data_in = dat[i];
            data_in_valid = vld[i];
            tick();
            $display("bp %0d valid=%b data=%h count=%0d", i, vld[i], dat[i], count);
        end
        data_in_valid = 1'b0;
        checks++;
        if (count !== 4'd2) begin errors++; $display("FAIL bp_count got %h exp 2", count); end
        checks++;
        if (get_sample(0) !== 8'hA0) begin errors++; $display("FAIL bp_sample0 got %h exp a0", get_sample(0)); end
        checks++;
        if (get_sample(1) !== 8'hA1) begin errors++; $display("FAIL bp_sample1 got %h exp a1", get_sample(1)); end
        checks++;
        if (get_sample(2) !== 8'h00) begin errors++; $display("FAIL bp_sample2 got %h exp 00", get_sample(2)); end
        // cnt_en must not step while the load window is open
        cnt_en = 1'b1;
        tick();
        cnt_en = 1'b0;
        checks++;
        if (count !== 4'd2) begin errors++; $display("FAIL bp_cnt_en_ignored got %h exp 2", count); end
        // valid outside the load window is ignored entirely
        dl_en = 1'b0;
        data_in = 8'h77;
        data_in_valid = 1'b1;
        tick();
        data_in_valid = 1'b0;
        checks++;
        if (count !== 4'd2 || get_sample(2) !== 8'h00) begin errors++; $display("FAIL bp_dl_en_low got count=%h s2=%h exp count=2 s2=00", count, get_sample(2)); end
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL bp_no_overrun got %b exp 0", overrun); end
    endtask

    task automatic test_collisions();
        pulse_dt_load();
        load_samples(3, 8'h31);
        checks++;
        if (count !== 4'd3) begin errors++; $display("FAIL col_setup3 got %h exp 3", count); end
        dt_load = 1'b1;
        dl_en = 1'b1;
        cnt_en = 1'b1;
        data_in = 8'h99;
        data_in_valid = 1'b1;
        #1;
        checks++;
        if (data_ready !== 1'b0) begin errors++; $display("FAIL col_ready_dt_load got %b exp 0", data_ready); end
        tick();
        dt_load = 1'b0;
        cnt_en = 1'b0;
        data_in_valid = 1'b0;
        checks++;
        if (count !== 4'd0) begin errors++; $display("FAIL col_dt_load_count got %h exp 0", count); end
        checks++;
        if (samples !== 64'h0) begin errors++; $display("FAIL col_dt_load_samples got %h exp 0", samples); end
        $display("collision dt_load: count=%0d samples=%h", count, samples);
        load_samples(5, 8'h41);
        checks++;
        if (count !== 4'd5 || samples !== 64'h0000004544434241) begin errors++; $display("FAIL col_setup5 got count=%h samples=%h exp 5 0000004544434241", count, samples); end
        rst = 1'b0;
        data_in = 8'h46;
        data_in_valid = 1'b1;
        tick();
        checks++;
        if (count !== 4'd0 || frame_full !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL col_rst_flags got count=%h full=%b ovr=%b exp 0 0 0", count, frame_full, overrun); end
        checks++;
        if (samples !== 64'h0) begin errors++; $display("FAIL col_rst_samples got %h exp 0", samples); end
        checks++;
        if (data_ready !== 1'b0) begin errors++; $display("FAIL col_rst_ready got %b exp 0", data_ready); end
        $display("collision rst: count=%0d samples=%h", count, samples);
        data_in_valid = 1'b0;
        rst = 1'b1;
        dl_en = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        dt_load = 1'b0;
        dl_en = 1'b0;
        cnt_en = 1'b0;
        data_in = 8'h00;
        data_in_valid = 1'b0;
        #2;
        test_reset();
        test_full_frame();
        test_overrun();
        test_step_count();
        test_backpressure();
        test_collisions();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
